mac_feeder: RTL and testbench

MAC_FEEDER -- requirements
Module: mac_feeder

---
 rtl/mac_feeder_if.sv | 20 ++
 rtl/mac_feeder.sv | 116 +++++++++++
 tb/tb_mac_feeder.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_feeder_if.sv
// Operand/result bus between the feeder and the MAC it drives.
// The feeder is the master; the MAC is the slave.
interface mac_feeder_if;
  logic signed [3:0]  in_a;
  logic signed [3:0]  in_b;
  logic               in_valid_a;
  logic               in_valid_b;
  logic signed [10:0] mac_out;
  logic               out_valid;

  modport master (
    output in_a, in_b, in_valid_a, in_valid_b,
    input  mac_out, out_valid
  );

  modport slave (
    input  in_a, in_b, in_valid_a, in_valid_b,
    output mac_out, out_valid
  );
endinterface

// File: rtl/mac_feeder.sv
// Buffers VEC_LEN signed operand pairs and streams them to a MAC, then waits
// (bounded by WAIT_MAX cycles) for the accumulated dot product.
module mac_feeder #(
  parameter int VEC_LEN  = 8,
  parameter int WAIT_MAX = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic signed [3:0]  wr_a,
  input  logic signed [3:0]  wr_b,
  input  logic               start,
  output logic [3:0]         buf_cnt,
  output logic               busy,
  output logic signed [10:0] result,
  output logic               result_valid,
  output logic               timeout,
  mac_feeder_if.master       mac
);
  localparam logic [3:0] LEN  = 4'(VEC_LEN);
  localparam logic [7:0] WMAX = 8'(WAIT_MAX);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t            state;
  logic [3:0]        idx;
  logic [7:0]        wait_cnt;
  logic signed [3:0] a_p1;
  logic signed [3:0] b_p1;
  logic              vld_p1;
  logic signed [3:0] mem_a [16];
  logic signed [3:0] mem_b [16];
  logic              wr_accept;

  // A full buffer never accepts, which also makes start win over a same-cycle write.
  assign wr_accept = (state == IDLE) && wr_en && (buf_cnt != LEN);

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_a[buf_cnt] <= wr_a;
      mem_b[buf_cnt] <= wr_b;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      idx          <= '0;
      wait_cnt     <= '0;
      a_p1         <= '0;
      b_p1         <= '0;
      vld_p1       <= 1'b0;
      buf_cnt      <= '0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      timeout      <= 1'b0;
      case (state)
        IDLE: begin
          // Pair 0 goes out on the same edge that accepts start.
          if (start && (buf_cnt == LEN)) begin
            state  <= SEND;
            busy   <= 1'b1;
            a_p1   <= mem_a[0];
            b_p1   <= mem_b[0];
            vld_p1 <= 1'b1;
            idx    <= 4'd1;
          end else if (wr_accept) begin
            buf_cnt <= buf_cnt + 4'd1;
          end
        end
        SEND: begin
          if (idx == LEN) begin
            a_p1     <= '0;
            b_p1     <= '0;
            vld_p1   <= 1'b0;
            wait_cnt <= '0;
            state    <= WAIT;
          end else begin
            a_p1 <= mem_a[idx];
            b_p1 <= mem_b[idx];
            idx  <= idx + 4'd1;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 8'd1;
          // A result arriving on the expiry cycle is still captured.
          if (mac.out_valid) begin
            result       <= mac.mac_out;
            result_valid <= 1'b1;
            buf_cnt      <= '0;
            busy         <= 1'b0;
            state        <= IDLE;
          end else if ((wait_cnt + 8'd1) == WMAX) begin
            timeout <= 1'b1;
            buf_cnt <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mac.in_a       = a_p1;
  assign mac.in_b       = b_p1;
  assign mac.in_valid_a = vld_p1;
  assign mac.in_valid_b = vld_p1;
endmodule

// File: tb/tb_mac_feeder.sv
// Scoreboard bench for mac_feeder: a behavioural MAC answers the feeder, and a
// monitor checks every operand beat and every result/timeout against queues.
module tb_mac_feeder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               wr_en;
  logic signed [3:0]  wr_a;
  logic signed [3:0]  wr_b;
  logic               start;
  logic [3:0]         buf_cnt;
  logic               busy;
  logic signed [10:0] result;
  logic               result_valid;
  logic               timeout;

  mac_feeder_if mac();

  mac_feeder #(.VEC_LEN(8), .WAIT_MAX(15)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_a(wr_a), .wr_b(wr_b),
    .start(start), .buf_cnt(buf_cnt), .busy(busy), .result(result),
    .result_valid(result_valid), .timeout(timeout), .mac(mac)
  );

  localparam int TMO = -9999;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_ops[$];
  int         exp_done[$];
  logic signed [3:0] va[8];
  logic signed [3:0] vb[8];

  bit mac_respond = 1'b1;
  bit force_ov    = 1'b0;
  int mac_delay   = 1;
  int acc = 0;
  int since = 0;
  bit armed = 1'b0;
  bit prev_v = 1'b0;
  int mon_got;
  int mon_exp;
  logic [7:0] mon_op;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Behavioural MAC: accumulates each beat, answers mac_delay cycles after the last one.
  always @(negedge clk) begin
    mac.out_valid = 1'b0;
    if (!reset) begin
      armed  = 1'b0;
      acc    = 0;
      since  = 0;
      prev_v = 1'b0;
    end else if (force_ov) begin
      mac.out_valid = 1'b1;
      mac.mac_out   = 11'sd100;
    end else if (mac.in_valid_a) begin
      if (!prev_v) acc = 0;
      acc   = acc + int'(mac.in_a) * int'(mac.in_b);
      armed = 1'b1;
      since = 0;
    end else if (armed) begin
      since++;
      if (mac_respond && since == mac_delay) begin
        mac.out_valid = 1'b1;
        mac.mac_out   = 11'(acc);
        armed         = 1'b0;
      end
    end
    prev_v = mac.in_valid_a;
  end

  // Monitor
  always @(negedge clk) begin
    if (mac.in_valid_a || mac.in_valid_b) begin
      check("valid_pair", int'(mac.in_valid_b), int'(mac.in_valid_a));
      mon_op = {mac.in_a, mac.in_b};
      if (exp_ops.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_operand: got %h, expected none", mon_op);
      end else begin
        check("operand", int'(mon_op), int'(exp_ops.pop_front()));
      end
    end else begin
      check("idle_operands_zero", int'({mac.in_a, mac.in_b}), 0);
    end
    if (result_valid || timeout) begin
      if (result_valid && timeout) begin
        n_vec++;
        n_err++;
        $display("FAIL both_pulses: got result_valid=1 timeout=1, expected one");
      end
      mon_got = result_valid ? int'(result) : TMO;
      if (exp_done.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got %0d, expected none", mon_got);
      end else begin
        mon_exp = exp_done.pop_front();
        check("done_event", mon_got, mon_exp);
      end
    end
  end

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_en = 1'b1;
      wr_a  = va[i];
      wr_b  = vb[i];
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input int exp_lat);
    int k;
    bit hit;
    k   = 0;
    hit = 1'b0;
    while (!hit && k < 60) begin
      @(negedge clk);
      k++;
      if (result_valid || timeout) hit = 1'b1;
    end
    wr_en = 1'b0;
    check("done_seen", int'(hit), 1);
    check("done_latency", k, exp_lat);
    @(negedge clk);
    check("pulse_one_cycle", int'(result_valid | timeout), 0);
  endtask

  // wr_mode: 0 none, 1 hold a write during SEND/WAIT, 2 write together with start
  task automatic send_vec(input int exp_res, input int exp_lat, input int wr_mode);
    for (int i = 0; i < 8; i++) exp_ops.push_back({va[i], vb[i]});
    exp_done.push_back(exp_res);
    @(negedge clk);
    start = 1'b1;
    if (wr_mode == 2) begin
      wr_en = 1'b1;
      wr_a  = 4'sd7;
      wr_b  = 4'sd7;
    end
    @(negedge clk);
    start = 1'b0;
    wr_en = (wr_mode == 1);
    wr_a  = 4'sd7;
    wr_b  = 4'sd7;
    check("start_latency_valid", int'(mac.in_valid_a), 1);
    check("busy_send", int'(busy), 1);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      check("send_valid", int'(mac.in_valid_a), 1);
    end
    @(negedge clk);
    check("valid_drop", int'(mac.in_valid_a), 0);
    check("busy_wait", int'(busy), 1);
    wait_done(exp_lat);
    check("buf_cnt_after", int'(buf_cnt), 0);
    check("busy_after", int'(busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of run, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    wr_en = 1'b0;
    start = 1'b0;
    wr_a  = '0;
    wr_b  = '0;
    repeat (2) @(negedge clk);
    check("rst_buf_cnt", int'(buf_cnt), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_result", int'(result), 0);
    check("rst_result_valid", int'(result_valid), 0);
    check("rst_timeout", int'(timeout), 0);
    check("rst_valid_a", int'(mac.in_valid_a), 0);
    check("rst_valid_b", int'(mac.in_valid_b), 0);
    reset = 1'b1;

    // 8 x (1,1) -> 8
    for (int i = 0; i < 8; i++) begin va[i] = 4'sd1; vb[i] = 4'sd1; end
    load(8);
    check("full_buf_cnt", int'(buf_cnt), 8);
    send_vec(8, 1, 0);
    check("result_t1", int'(result), 8);

    // extremes: 8 x (-8,-8) -> 512, 8 x (7,-8) -> -448 with writes held during SEND
    for (int i = 0; i < 8; i++) begin va[i] = -4'sd8; vb[i] = -4'sd8; end
    load(8);
    send_vec(512, 1, 0);
    for (int i = 0; i < 8; i++) begin va[i] = 4'sd7; vb[i] = -4'sd8; end
    load(8);
    send_vec(-448, 1, 1);
    check("result_t2", int'(result), -448);

    // partial buffer ignores start; 9th write dropped
    va[0] = 4'sd1;  vb[0] = 4'sd2;
    va[1] = 4'sd2;  vb[1] = 4'sd3;
    va[2] = 4'sd3;  vb[2] = -4'sd1;
    va[3] = -4'sd2; vb[3] = 4'sd4;
    va[4] = 4'sd5;  vb[4] = 4'sd5;
    va[5] = -4'sd3; vb[5] = -4'sd3;
    va[6] = 4'sd6;  vb[6] = 4'sd1;
    va[7] = -4'sd7; vb[7] = 4'sd2;
    load(5);
    check("partial_buf_cnt", int'(buf_cnt), 5);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("partial_start_busy", int'(busy), 0);
    check("partial_start_valid", int'(mac.in_valid_a), 0);
    check("partial_start_cnt", int'(buf_cnt), 5);
    for (int i = 5; i < 8; i++) begin
      @(negedge clk);
      wr_en = 1'b1;
      wr_a  = va[i];
      wr_b  = vb[i];
    end
    @(negedge clk);
    wr_a = 4'sd7;
    wr_b = 4'sd7;
    @(negedge clk);
    wr_en = 1'b0;
    check("overflow_buf_cnt", int'(buf_cnt), 8);
    send_vec(23, 1, 0);

    // 7 buffered: write+start together -> write wins; full: start+write -> start wins
    for (int i = 0; i < 7; i++) begin va[i] = 4'(i + 1); vb[i] = 4'sd1; end
    va[7] = -4'sd1;
    vb[7] = -4'sd1;
    load(7);
    check("seven_buf_cnt", int'(buf_cnt), 7);
    @(negedge clk);
    wr_en = 1'b1;
    wr_a  = va[7];
    wr_b  = vb[7];
    start = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    start = 1'b0;
    check("tie_buf_cnt", int'(buf_cnt), 8);
    check("tie_busy", int'(busy), 0);
    check("tie_valid", int'(mac.in_valid_a), 0);
    send_vec(29, 1, 2);
    check("result_t6", int'(result), 29);

    // silent MAC -> timeout 15 cycles after WAIT entry, result held
    mac_respond = 1'b0;
    for (int i = 0; i < 8; i++) begin va[i] = 4'sd2; vb[i] = 4'sd3; end
    load(8);
    send_vec(TMO, 15, 0);
    check("result_held", int'(result), 29);
    mac_respond = 1'b1;

    // out_valid on the expiry cycle -> capture, no timeout
    mac_delay = 15;
    for (int i = 0; i < 8; i++) begin va[i] = 4'sd1; vb[i] = -4'sd1; end
    load(8);
    send_vec(-8, 15, 0);
    mac_delay = 1;

    // out_valid in IDLE is ignored
    @(posedge clk);
    force_ov = 1'b1;
    @(posedge clk);
    force_ov = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_ov_no_pulse", int'(result_valid), 0);
    check("idle_ov_result", int'(result), -8);

    // reset in the 4th SEND cycle
    for (int i = 0; i < 8; i++) begin va[i] = 4'(i + 1); vb[i] = 4'sd2; end
    load(8);
    for (int i = 0; i < 4; i++) exp_ops.push_back({va[i], vb[i]});
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_valid_a", int'(mac.in_valid_a), 0);
    check("abort_valid_b", int'(mac.in_valid_b), 0);
    check("abort_buf_cnt", int'(buf_cnt), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_result", int'(result), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_pulse", int'(result_valid | timeout), 0);
    end
    reset = 1'b1;

    // recovery after abort
    for (int i = 0; i < 8; i++) begin va[i] = 4'sd1; vb[i] = 4'sd1; end
    load(8);
    send_vec(8, 1, 0);

    repeat (3) @(negedge clk);
    check("ops_drained", exp_ops.size(), 0);
    check("done_drained", exp_done.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
